// File: rtl/dp_sequencer.sv
// dp_sequencer: control unit for the 4-bit arithmetic datapath.
// Accepts a start/opcode request and steps the datapath through
// load, execute, wait-for-done, select and output-enable phases,
// rejecting divide-by-zero and aborting a WAIT that never completes.
// All outputs come straight from flops so they are glitch-free and
// clear together with the asynchronous reset.
module dp_sequencer #(
    parameter int unsigned TIMEOUT = 15,  // max WAIT cycles before err (1..255)
    parameter int unsigned CW      = 8    // timeout counter width
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [3:0] y,
    input  logic       done_calc,
    input  logic       done_div,
    output logic       en_x,
    output logic       en_y,
    output logic       go_calc,
    output logic       go_div,
    output logic       go_mult,
    output logic       sel_h,
    output logic [1:0] sel_l,
    output logic       en_out_h,
    output logic       en_out_l,
    output logic [2:0] op_calc,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WAIT,
        S_SEL,
        S_OUT,
        S_FIN,
        S_ERR
    } state_t;

    // Full datapath control word, in output-port order.
    typedef struct packed {
        logic       en_x;
        logic       en_y;
        logic       go_calc;
        logic       go_div;
        logic       go_mult;
        logic       sel_h;
        logic [1:0] sel_l;
        logic       en_out_h;
        logic       en_out_l;
        logic [2:0] op_calc;
        logic       busy;
        logic       done;
        logic       err;
    } ctrl_t;

    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_CALC = 2'b01;
    localparam logic [1:0] SEL_MUL  = 2'b10;
    localparam logic [1:0] SEL_DIV  = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q;
    ctrl_t         ctrl_q, ctrl_d;
    logic          unit_done;
    logic          timeout_hit;

    // Opcode classes: calc ops are 000-011, pass ops are 110/111.
    function automatic logic is_calc(input logic [2:0] o);
        return (o[2] == 1'b0);
    endfunction

    function automatic logic is_pass(input logic [2:0] o);
        return (o[2:1] == 2'b11);
    endfunction

    // Moore decode of the control word for a given state and latched opcode.
    function automatic ctrl_t decode(input state_t s, input logic [2:0] o);
        ctrl_t c;
        c = '0;
        if (s != S_IDLE) begin
            c.op_calc = o;
        end
        case (s)
            S_LOAD: begin
                c.en_x = 1'b1;
                c.en_y = 1'b1;
                c.busy = 1'b1;
            end
            S_EXEC: begin
                c.go_calc = is_calc(o);
                c.go_div  = (o == OP_DIV);
                c.go_mult = (o == OP_MUL);
                c.busy    = 1'b1;
            end
            S_WAIT: begin
                c.busy = 1'b1;
            end
            S_SEL, S_OUT: begin
                c.busy = 1'b1;
                if (is_calc(o)) begin
                    c.sel_l = SEL_CALC;
                end else if (o == OP_DIV) begin
                    c.sel_h = 1'b1;
                    c.sel_l = SEL_DIV;
                end else if (o == OP_MUL) begin
                    c.sel_l = SEL_MUL;
                end else begin
                    c.sel_l = SEL_PASS;
                end
                if (s == S_OUT) begin
                    c.en_out_l = 1'b1;
                    c.en_out_h = (o == OP_DIV) || (o == OP_MUL);
                end
            end
            S_FIN: begin
                c.done = 1'b1;
            end
            S_ERR: begin
                c.err  = 1'b1;
                c.busy = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    assign unit_done   = (op_q == OP_DIV) ? done_div : done_calc;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Next-state, opcode latch and next control word.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    if ((op == OP_DIV) && (y == 4'b0000)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_d = is_pass(op_q) ? S_SEL : S_EXEC;
            end
            S_EXEC: begin
                // The multiplier registers its result on go, so no WAIT.
                state_d = (op_q == OP_MUL) ? S_SEL : S_WAIT;
            end
            S_WAIT: begin
                // A done in the last allowed cycle still wins over timeout.
                if (unit_done) begin
                    state_d = S_SEL;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_SEL: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ctrl_d = decode(state_d, op_d);
    end

    // State, latched opcode and registered control word.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // WAIT-cycle counter, cleared in EXEC so the first WAIT cycle sees 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_EXEC) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign en_x     = ctrl_q.en_x;
    assign en_y     = ctrl_q.en_y;
    assign go_calc  = ctrl_q.go_calc;
    assign go_div   = ctrl_q.go_div;
    assign go_mult  = ctrl_q.go_mult;
    assign sel_h    = ctrl_q.sel_h;
    assign sel_l    = ctrl_q.sel_l;
    assign en_out_h = ctrl_q.en_out_h;
    assign en_out_l = ctrl_q.en_out_l;
    assign op_calc  = ctrl_q.op_calc;
    assign busy     = ctrl_q.busy;
    assign done     = ctrl_q.done;
    assign err      = ctrl_q.err;

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Control unit for the 4-bit arithmetic datapath: x/y input registers, a calc unit (add/sub/and/xor), an iterative divider, a multiplier, output muxes and out_h/out_l registers.
- Accepts a start request with a 3-bit opcode, then emits the datapath control word cycle by cycle: load, execute, wait for done, select, output enable.
- Adds divide-by-zero rejection, a wait timeout, and a busy/done/err handshake for the board-level top.

Parameters:
- TIMEOUT, 15, maximum WAIT cycles before aborting with err (1..255).
- CW, 8, width of the internal timeout counter.

Ports:
- clk        in   1  system clock, rising edge
- rst        in   1  asynchronous active-high reset
- start      in   1  begin operation; sampled only in IDLE
- op         in   3  opcode: 000 add, 001 sub, 010 and, 011 xor, 100 div, 101 mul, 110 passA, 111 passB
- y          in   4  divisor operand, same value presented to datapath y; checked for zero at start
- done_calc  in   1  calc unit result valid
- done_div   in   1  divider result valid
- en_x       out  1  load x register
- en_y       out  1  load y register
- go_calc    out  1  start calc unit
- go_div     out  1  start divider
- go_mult    out  1  start multiplier
- sel_h      out  1  out_h mux select (1 = divider remainder)
- sel_l      out  2  out_l mux select: 00 pass, 01 calc, 10 mul, 11 div
- en_out_h   out  1  load out_h register
- en_out_l   out  1  load out_l register
- op_calc    out  3  datapath opcode
- busy       out  1  high from the cycle after an accepted start through the OUT or ERR state
- done       out  1  one-cycle pulse, operation complete, output registers updated
- err        out  1  one-cycle pulse, divide-by-zero or timeout

Behaviour:
- States: IDLE, LOAD, EXEC, WAIT, SEL, OUT, FIN, ERR. State is registered. All outputs are Moore, decoded from the state and the latched opcode.
- Reset value: every output is 0, state is IDLE, op_reg is 000, counter is 0. Asserting rst mid-operation returns to IDLE asynchronously and drops all go and enable outputs in the same instant.
- IDLE: if start=1, latch op into op_reg.
  - If op=100 and y=0000, go to ERR.
  - Otherwise go to LOAD.
  - start in any other state is ignored and does not queue.
- LOAD: en_x=en_y=1. Next state is EXEC for ops 000-101, SEL for 110/111.
- EXEC: for one cycle, assert go_calc (ops 000-011), go_div (100) or go_mult (101). Next state is WAIT for 000-100, SEL for 101 (multiplier result is registered on go).
- WAIT: the go signal is deasserted and the counter increments each cycle.
  - Exit to SEL on done_calc (ops 000-011) or done_div (100), sampled every WAIT cycle including the first.
  - If the counter reaches TIMEOUT with no done, go to ERR.
  - The counter clears on entry to EXEC.
- SEL: drive sel_l/sel_h for the op: calc sel_l=01; div sel_h=1, sel_l=11; mul sel_l=10; pass sel_l=00. Next state is OUT.
- OUT: the SEL values are held and en_out_l=1. en_out_h=1 only for div and mul. Next state is FIN.
- FIN: done=1 for one cycle, busy=0. Next state is IDLE. A start in FIN is ignored.
- ERR: err=1 for one cycle, no enables asserted, out registers unchanged. Next state is IDLE.
- op_calc = op_reg in every state except IDLE, where it is 000.
- busy=1 in LOAD, EXEC, WAIT, SEL, OUT and ERR.
- Fixed latencies, counted in cycles from the start edge to the done pulse:
  - add with done_calc returned in the first WAIT cycle: LOAD, EXEC, WAIT, SEL, OUT, FIN = 6.
  - mul: 5.
  - pass: 4.
  - div: 5 + number of WAIT cycles.
- done and err are mutually exclusive. No output glitches between states.

Test Plan:
- op=000, x=1110, y=0011, done_calc returned one cycle after go_calc → go_calc high exactly 1 cycle, sel_l=01 during SEL/OUT, en_out_l pulse, done 6 cycles after start; datapath out_l=0001.
- op=100, x=1110, y=0101, done_div after 6 cycles → go_div 1 cycle, sel_h=1/sel_l=11, en_out_h=en_out_l=1 for 1 cycle, done; out_l=0010, out_h=0100.
- op=101, x=1110, y=0101 → no WAIT, sel_l=10, both enables, done 5 cycles after start; {out_h,out_l}=0100_0110.
- op=100, y=0000 → err pulse the cycle after start, no en_x/en_y/go_div, busy high for 1 cycle; op=110, x=1001 → done after 4 cycles, out_l=1001.
- op=000 with done_calc held low → err after TIMEOUT=15 WAIT cycles, no output enable; a start pulse during busy produces no second operation.
- rst asserted during div WAIT → all outputs 0 immediately, state IDLE; the next start runs normally.
